// File: rtl/mem_block_summer_if.sv
// Command, status and data-memory bus bundle for mem_block_summer.
// The master modport is the summer's view; slave is the control/memory side.
interface mem_block_summer_if;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned SUM_W  = 16;

   // command from control logic
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] dst_addr;

   // data memory bus
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ld;
   logic [DATA_W-1:0] mem_rdata;

   // status
   logic              busy;
   logic              done;
   logic [SUM_W-1:0]  sum;

   modport master (
      input  start, base_addr, count, dst_addr, mem_rdata,
      output mem_addr, mem_wdata, mem_ld, busy, done, sum
   );

   modport slave (
      output start, base_addr, count, dst_addr, mem_rdata,
      input  mem_addr, mem_wdata, mem_ld, busy, done, sum
   );
endinterface

// File: rtl/mem_block_summer.sv
// Reads a run of bytes from the data memory, sums them modulo 2^16 and
// writes the sum back little-endian at dst/dst+1. All outputs registered.
module mem_block_summer (
   input  logic                clk,
   input  logic                rst_n,
   mem_block_summer_if.master  bus
);
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned SUM_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_SET,
      S_RD_CAP,
      S_WR_LO,
      S_WR_HI,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [SUM_W-1:0]  acc_q, acc_d;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_ld_q, mem_ld_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [SUM_W-1:0]  sum_q, sum_d;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         dst_q       <= '0;
         acc_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_ld_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sum_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         dst_q       <= dst_d;
         acc_q       <= acc_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_ld_q    <= mem_ld_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sum_q       <= sum_d;
      end
   end

   // Next state and datapath; outputs are decoded from the next state so
   // the registered bus lines up with the state they belong to.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      dst_d       = dst_q;
      acc_d       = acc_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_ld_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      sum_d       = sum_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ptr_d   = bus.base_addr;
               rem_d   = bus.count;
               dst_d   = bus.dst_addr;
               acc_d   = '0;
               state_d = (bus.count == '0) ? S_WR_LO : S_RD_SET;
            end
         end
         S_RD_SET: state_d = S_RD_CAP;
         S_RD_CAP: begin
            acc_d   = acc_q + SUM_W'(bus.mem_rdata);
            ptr_d   = ptr_q + ADDR_W'(1);
            rem_d   = rem_q - ADDR_W'(1);
            state_d = (rem_q > ADDR_W'(1)) ? S_RD_SET : S_WR_LO;
         end
         S_WR_LO: state_d = S_WR_HI;
         S_WR_HI: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_RD_SET: begin
            mem_addr_d = ptr_d;
            busy_d     = 1'b1;
         end
         S_RD_CAP: busy_d = 1'b1;
         S_WR_LO: begin
            mem_addr_d  = dst_d;
            mem_wdata_d = acc_d[DATA_W-1:0];
            mem_ld_d    = 1'b1;
            busy_d      = 1'b1;
         end
         S_WR_HI: begin
            mem_addr_d  = dst_q + ADDR_W'(1);
            mem_wdata_d = acc_q[SUM_W-1:DATA_W];
            mem_ld_d    = 1'b1;
            busy_d      = 1'b1;
         end
         S_DONE: begin
            done_d = 1'b1;
            sum_d  = acc_q;
         end
         default: ;
      endcase
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_ld    = mem_ld_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;

endmodule
